// File: rtl/tl_log_div16_if.sv
// Operand/result handshake bundle for the Mitchell-log divider.
// slave is the divider side, master the producer/consumer side.
interface tl_log_div16_if;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [23:0] q_o;
  logic        dz_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport slave (
    input  a_i, b_i, in_valid_i, out_ready_i,
    output in_ready_o, q_o, dz_o, out_valid_o
  );

  modport master (
    output a_i, b_i, in_valid_i, out_ready_i,
    input  in_ready_o, q_o, dz_o, out_valid_o
  );
endinterface

// File: rtl/tl_log_div16.sv
// Three-stage signed 16/16 divider using Mitchell's log approximation.
// Result is Q16.8 with ones'-complement sign; divide-by-zero saturates.
module tl_log_div16 (
  input  logic            clk_i,
  input  logic            rst_i,
  tl_log_div16_if.slave   bus
);

  // Mitchell log: {leading-one position, next four bits below it}
  function automatic logic [7:0] mlog(input logic [15:0] m);
    logic [3:0]  k;
    logic [19:0] sh;
    k = '0;
    for (int j = 0; j < 16; j++) begin
      if (m[j]) k = 4'(j);
    end
    sh = {m, 4'b0} >> k;
    return {k, sh[3:0]};
  endfunction

  logic en;
  logic [15:0] mag_a, mag_b;

  // Stage 1
  logic       v1_q;
  logic [7:0] la_q, lb_q;
  logic       s1_q, za1_q, zb1_q;
  // Stage 2
  logic       v2_q;
  logic [8:0] d_q;
  logic       s2_q, za2_q, zb2_q;
  // Stage 3 (output)
  logic        out_valid_q;
  logic [23:0] q_q, q_d;
  logic        dz_q, dz_d;

  logic signed [5:0] sh_s;
  logic [5:0]        sh_l, sh_r;
  logic [4:0]        mant;
  logic [23:0]       qm;

  assign en    = bus.out_ready_i | ~out_valid_q;
  assign mag_a = bus.a_i ^ {16{bus.a_i[15]}};
  assign mag_b = bus.b_i ^ {16{bus.b_i[15]}};

  always_comb begin
    sh_s = $signed({d_q[8], d_q[8:4]}) + 6'sd4;
    sh_l = sh_s;
    sh_r = -sh_s;
    mant = {1'b1, d_q[3:0]};
    qm   = '0;
    if (sh_s >= 0) qm = 24'(mant) << sh_l;
    else           qm = 24'(mant) >> sh_r;

    q_d  = {24{s2_q}} ^ qm;
    dz_d = 1'b0;
    if (zb2_q) begin
      dz_d = 1'b1;
      q_d  = s2_q ? 24'h800000 : 24'h7FFFFF;
    end else if (za2_q) begin
      q_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dz_q        <= 1'b0;
    end else if (en) begin
      v1_q        <= bus.in_valid_i;
      la_q        <= mlog(mag_a);
      lb_q        <= mlog(mag_b);
      s1_q        <= bus.a_i[15] ^ bus.b_i[15];
      za1_q       <= (mag_a == 16'h0);
      zb1_q       <= (mag_b == 16'h0);

      v2_q        <= v1_q;
      d_q         <= {1'b0, la_q} - {1'b0, lb_q};
      s2_q        <= s1_q;
      za2_q       <= za1_q;
      zb2_q       <= zb1_q;

      out_valid_q <= v2_q;
      q_q         <= q_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.in_ready_o  = en;
  assign bus.out_valid_o = out_valid_q;
  assign bus.q_o         = q_q;
  assign bus.dz_o        = dz_q;

endmodule

// File: doc/tl_log_div16.md
TL_LOG_DIV16 -- requirements
Module: tl_log_div16

Interface
REQ-001: Clock and reset SHALL be: clk_i  in  1  rising-edge clock, the only clock; rst_i  in  1  synchronous, active-high reset.
REQ-002: Data and handshake ports SHALL be:
- a_i  in  16  signed dividend
- b_i  in  16  signed divisor
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  block accepts operands
- q_o  out  24  signed quotient, Q16.8, ones'-complement sign encoding
- dz_o  out  1  divide-by-zero flag, qualified by out_valid_o
- out_valid_o  out  1  q_o/dz_o valid
- out_ready_i  in  1  downstream accepts result
REQ-003: The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004: Pipeline enable SHALL be en = out_ready_i | ~out_valid_o; in_ready_o = en; all three stages advance together when en=1 and hold when en=0.
REQ-005: An operand pair SHALL be accepted on a cycle with in_valid_i & in_ready_o; the stage-1 valid bit loads in_valid_i whenever en=1.
REQ-006: Latency SHALL be 3 cycles from acceptance to out_valid_o with no stall; throughput SHALL be one result per cycle; bubbles SHALL propagate, not collapse.
REQ-007: Stage 1 SHALL form the magnitude |x| = x ^ {16{x[15]}} for both operands, latch sign s = a_i[15] ^ b_i[15], and latch za = (|a|==0) and zb = (|b|==0).
REQ-008: Stage 1 SHALL compute each Mitchell log L = {k[3:0], f[3:0]}, where k is the leading-one position of |x| and f is the 4 bits directly below the leading one, zero-filled on the right when k<4.
REQ-009: Stage 2 SHALL compute D = L_a - L_b as a 9-bit two's-complement value in the range -255..255.
REQ-010: Stage 3 SHALL decode D as integer part i = D[8:4] (signed, -16..15) and fraction D[3:0], and form mantissa m = {1'b1, D[3:0]}.
REQ-011: Stage 3 SHALL form magnitude Qm = m shifted left by (i+4) when i+4 >= 0, else m shifted right by -(i+4) with truncation, held in 24 bits; no overflow is possible.
REQ-012: Output SHALL be q_o = {24{s}} ^ Qm and dz_o = 0 when za=0 and zb=0.
REQ-013: When za=1 and zb=0, output SHALL be q_o = 24'h000000 and dz_o = 0.
REQ-014: When zb=1, output SHALL be dz_o = 1 and q_o = 24'h7FFFFF if s=0, else 24'h800000; this includes the case za=1.
REQ-015: Inputs 0x0000 and 0xFFFF SHALL both be treated as zero magnitude.
REQ-016: q_o and dz_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-017: While rst_i=1 at a clock edge, all stage valid bits SHALL clear, out_valid_o = 0, q_o = 0, and dz_o = 0.
REQ-018: Datapath registers other than the output registers need not reset.
REQ-019: Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear afterwards.
REQ-020: in_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-021: a=100, b=10, out_ready_i=1 -> 3 cycles later out_valid_o=1, q_o=24'h000A80 (10.5), dz_o=0.
REQ-022: a=1,b=1 -> q_o=24'h000100; a=1,b=4 -> q_o=24'h000040 (0.25); a=-100 (0xFF9C), b=10 -> q_o=24'hFFF5FF.
REQ-023: a=5, b=0 -> dz_o=1, q_o=24'h7FFFFF; a=-5, b=0 -> q_o=24'h800000; a=0, b=7 -> q_o=0, dz_o=0.
REQ-024: Stream 6 back-to-back pairs, hold out_ready_i=0 after the first result -> in_ready_o=0 and q_o held; on release, remaining results emerge in order, none lost or duplicated.
REQ-025: Assert rst_i for 1 cycle with 2 operands in flight -> out_valid_o=0 for the next 3 cycles with no new input; in_ready_o=1 after reset deasserts.
REQ-026: Random signed operands -> every q_o matches a bit-exact reference model of REQ-007..REQ-015.
